// File: rtl/pc_stack_pkg.sv
// Shared definitions for the program-counter / return-address-stack block:
// op-code encoding and the raw-to-enum decode used by the next-PC mux.
package pc_stack_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD   = 3'd0,
        OP_INC    = 3'd1,
        OP_LOAD   = 3'd2,
        OP_BRANCH = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5
    } op_e;

    // Unassigned codes collapse onto HOLD so they can never disturb state.
    function automatic op_e decode_op(input logic [OP_W-1:0] raw);
        op_e res;
        case (raw)
            3'd1:    res = OP_INC;
            3'd2:    res = OP_LOAD;
            3'd3:    res = OP_BRANCH;
            3'd4:    res = OP_CALL;
            3'd5:    res = OP_RET;
            default: res = OP_HOLD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address LIFO: a small storage array with an occupancy counter.
// Entry contents are not reset; only entries below sp are ever observed.
module pc_ras
    import pc_stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           push_data_i,
    output logic [WIDTH-1:0]           top_o,
    output logic [$clog2(DEPTH+1)-1:0] sp_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    rd_idx_s;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_s    = (sp_q == SPW'(DEPTH));
    assign empty_s   = (sp_q == {SPW{1'b0}});
    assign push_ok_s = push_i && !full_s;
    assign pop_ok_s  = pop_i && !empty_s && !push_ok_s;
    assign wr_idx_s  = AW'(sp_q);
    assign rd_idx_s  = AW'(sp_q - SPW'(1));

    // Occupancy next-state: clear, push, pop or hold.
    always_comb begin
        sp_d = sp_q;
        if (clr_i) begin
            sp_d = {SPW{1'b0}};
        end else if (push_ok_s) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop_ok_s) begin
            sp_d = sp_q - SPW'(1);
        end else begin
            sp_d = sp_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= {SPW{1'b0}};
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage write port; a clear takes precedence over any push.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clr_i) begin
            mem_q[wr_idx_s] <= push_data_i;
        end
    end

    assign top_o   = empty_s ? {WIDTH{1'b0}} : mem_q[rd_idx_s];
    assign sp_o    = sp_q;
    assign full_o  = full_s;
    assign empty_o = empty_s;

endmodule

// File: rtl/pc_stack.sv
// Program counter with call/return stack: PC register, next-PC mux and the
// sticky overflow/underflow flags; the LIFO itself lives in pc_ras.
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       stall_i,
    input  logic [OP_W-1:0]            op_i,
    input  logic [WIDTH-1:0]           in_i,
    output logic [WIDTH-1:0]           out_o,
    output logic [$clog2(DEPTH+1)-1:0] sp_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       ovf_o,
    output logic                       unf_o
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] top_s;
    logic [WIDTH-1:0] ret_addr_s;
    logic             full_s;
    logic             empty_s;

    assign ret_addr_s = out_q + WIDTH'(1);

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr_i),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .push_data_i (ret_addr_s),
        .top_o       (top_s),
        .sp_o        (sp_o),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

    // Next-PC mux and flag update; stack strobes only fire on a live op.
    always_comb begin
        out_d  = out_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (clr_i) begin
            out_d = RESET_VEC;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (stall_i) begin
            out_d = out_q;
        end else begin
            case (decode_op(op_i))
                OP_INC:    out_d = ret_addr_s;
                OP_LOAD:   out_d = in_i;
                OP_BRANCH: out_d = out_q + in_i;
                OP_CALL: begin
                    out_d = in_i;
                    if (full_s) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_s = 1'b1;
                    end
                end
                OP_RET: begin
                    if (empty_s) begin
                        unf_d = 1'b1;
                    end else begin
                        out_d = top_s;
                        pop_s = 1'b1;
                    end
                end
                default:   out_d = out_q;
            endcase
        end
    end

    // PC and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= RESET_VEC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign out_o   = out_q;
    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: a queue-based reference model predicts each
// edge's result; an independent monitor pops and compares after every edge.
module tb_pc_stack;
    import pc_stack_pkg::*;

    localparam int          W   = 16;
    localparam int          D   = 8;
    localparam int          SPW = $clog2(D + 1);
    localparam logic [W-1:0] RV = 16'h0000;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           clr   = 1'b0;
    logic           stall = 1'b0;
    logic [2:0]     op    = 3'd0;
    logic [W-1:0]   din   = 16'h0000;
    logic [W-1:0]   out;
    logic [SPW-1:0] sp;
    logic           full, empty, ovf, unf;

    pc_stack #(.WIDTH(W), .DEPTH(D), .RESET_VEC(RV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .stall_i (stall),
        .op_i    (op),
        .in_i    (din),
        .out_o   (out),
        .sp_o    (sp),
        .full_o  (full),
        .empty_o (empty),
        .ovf_o   (ovf),
        .unf_o   (unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] pc;
        int           sp;
        bit           ovf;
        bit           unf;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    event sample_ev;

    // Reference model: PC as a W-bit value, stack as a plain queue.
    bit [W-1:0] m_pc;
    bit [W-1:0] m_stk[$];
    bit         m_ovf, m_unf;

    function automatic void m_reset();
        m_pc = RV;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic exp_t m_snap();
        exp_t e;
        e.pc  = m_pc;
        e.sp  = m_stk.size();
        e.ovf = m_ovf;
        e.unf = m_unf;
        return e;
    endfunction

    function automatic void m_step(bit c, bit s, int o, bit [W-1:0] v);
        if (c) begin
            m_reset();
        end else if (!s) begin
            case (o)
                1: m_pc = m_pc + 16'd1;
                2: m_pc = v;
                3: m_pc = m_pc + v;
                4: begin
                    if (m_stk.size() < D) m_stk.push_back(m_pc + 16'd1);
                    else m_ovf = 1'b1;
                    m_pc = v;
                end
                5: begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else m_unf = 1'b1;
                end
                default: m_pc = m_pc;
            endcase
        end
    endfunction

    task automatic cyc(input bit c, input bit s, input int o, input logic [W-1:0] v);
        int oo;
        oo = o;
        @(negedge clk);
        m_step(c, s, o, v);
        exp_q.push_back(m_snap());
        clr   = c;
        stall = s;
        op    = oo[2:0];
        din   = v;
    endtask

    // Reset pulsed between edges while an op is presented; the op executes
    // at the first edge after release.
    task automatic reset_pulse(input int o, input logic [W-1:0] v);
        int oo;
        oo = o;
        @(negedge clk);
        clr   = 1'b0;
        stall = 1'b0;
        op    = oo[2:0];
        din   = v;
        #1;
        rst_n = 1'b0;
        m_reset();
        exp_q.push_back(m_snap());
        ->sample_ev;
        #2;
        rst_n = 1'b1;
        m_step(1'b0, 1'b0, o, v);
        exp_q.push_back(m_snap());
    endtask

    // Monitor: compare after each edge and after each asynchronous reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or sample_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (out !== e.pc || sp !== SPW'(e.sp) || full !== (e.sp == D) ||
                    empty !== (e.sp == 0) || ovf !== e.ovf || unf !== e.unf) begin
                    miscompares++;
                    $display("FAIL state vec%0d t=%0t: got out=%h sp=%0d full=%b empty=%b ovf=%b unf=%b, exp out=%h sp=%0d full=%b empty=%b ovf=%b unf=%b",
                             vectors, $time, out, sp, full, empty, ovf, unf,
                             e.pc, e.sp, (e.sp == D), (e.sp == 0), e.ovf, e.unf);
                end
            end
        end
    end

    initial begin
        int o;
        m_reset();
        exp_q.push_back(m_snap());
        #1 ->sample_ev;
        #3 rst_n = 1'b1;

        repeat (3) cyc(0, 0, OP_INC, 16'h0);
        cyc(0, 0, OP_LOAD, 16'hFFFF);
        cyc(0, 0, OP_INC, 16'h0);

        cyc(0, 0, OP_LOAD, 16'd100);
        cyc(0, 0, OP_BRANCH, 16'hFFF6);
        cyc(0, 0, OP_BRANCH, 16'd20);
        cyc(0, 0, OP_LOAD, 16'd7);

        cyc(0, 0, OP_LOAD, 16'd10);
        cyc(0, 0, OP_CALL, 16'd200);
        cyc(0, 0, OP_CALL, 16'd300);
        cyc(0, 0, OP_RET, 16'h0);
        cyc(0, 0, OP_RET, 16'h0);

        for (int i = 0; i < D; i++) cyc(0, 0, OP_CALL, 16'(i * 16 + 3));
        cyc(0, 0, OP_CALL, 16'd55);
        for (int i = 0; i < D; i++) cyc(0, 0, OP_RET, 16'h0);
        cyc(0, 0, OP_RET, 16'h0);
        cyc(0, 0, OP_HOLD, 16'h1234);
        cyc(0, 0, 6, 16'h0);
        cyc(0, 0, OP_INC, 16'h0);
        cyc(1, 0, OP_INC, 16'h0);

        cyc(0, 0, OP_CALL, 16'd1000);
        repeat (3) cyc(0, 1, OP_CALL, 16'd5);
        cyc(0, 1, OP_RET, 16'h0);
        cyc(1, 1, OP_CALL, 16'd5);

        cyc(0, 0, OP_CALL, 16'd40);
        reset_pulse(OP_CALL, 16'd77);
        cyc(0, 0, OP_CALL, 16'd88);
        cyc(0, 0, OP_RET, 16'h0);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_pulse(OP_CALL, 16'($urandom));
            end else begin
                o = $urandom_range(0, 9);
                if (o > 7) o = OP_CALL;
                cyc($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, o, 16'($urandom));
            end
        end
        cyc(0, 0, OP_HOLD, 16'h0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the width of the program counter and address data.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of return-address stack entries (DEPTH >= 2).
REQ-003 Parameter RESET_VEC, default 0, SHALL set the PC value loaded by reset and by clr.
REQ-004 clock  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 clr  input  1  synchronous clear to RESET_VEC; highest synchronous priority.
REQ-007 stall  input  1  hold all state; op ignored.
REQ-008 op  input  3  operation code (package encoding).
REQ-009 in  input  WIDTH  jump target, or signed branch offset.
REQ-010 out  output  WIDTH  current PC, registered.
REQ-011 sp  output  clog2(DEPTH+1)  number of stack entries in use.
REQ-012 full  output  1  sp == DEPTH.
REQ-013 empty  output  1  sp == 0.
REQ-014 ovf  output  1  sticky flag: CALL attempted while full.
REQ-015 unf  output  1  sticky flag: RET attempted while empty.

Function
REQ-016 Op codes SHALL be: HOLD=0, INC=1, LOAD=2, BRANCH=3, CALL=4, RET=5; codes 6-7 SHALL behave as HOLD.
REQ-017 Every op SHALL take effect at the first rising edge where it is sampled; out SHALL show the result one cycle later (latency 1).
REQ-018 Priority per edge SHALL be: clr > stall > op.
REQ-019 clr SHALL set out=RESET_VEC, sp=0, ovf=0, unf=0.
REQ-020 stall=1 SHALL hold out, sp, stack contents and flags, and SHALL NOT set any error flag.
REQ-021 HOLD SHALL keep out unchanged.
REQ-022 INC SHALL set out = out+1 modulo 2^WIDTH (all-ones wraps to 0).
REQ-023 LOAD SHALL set out = in.
REQ-024 BRANCH SHALL set out = out + in, with in treated as two's complement and the sum modulo 2^WIDTH.
REQ-025 CALL when not full SHALL push (out+1 mod 2^WIDTH), increment sp, and set out = in.
REQ-026 CALL when full SHALL set out = in, leave the stack and sp unchanged, and set ovf.
REQ-027 RET when not empty SHALL set out = top entry and decrement sp.
REQ-028 RET when empty SHALL hold out and sp, and set unf.
REQ-029 ovf and unf SHALL clear only on reset or clr.
REQ-030 full, empty and sp SHALL be derived combinationally from registered sp, with no extra latency.
REQ-031 Stack entries above sp SHALL have no observable effect on outputs.

Reset
REQ-032 reset low SHALL immediately force out=RESET_VEC, sp=0, empty=1, full=0, ovf=0, unf=0, regardless of clock.
REQ-033 Reset asserted mid-operation SHALL abandon the in-flight op; the first edge after reset release SHALL execute the op present at that edge.
REQ-034 Stack RAM contents need not be reset.

Structure
REQ-035 A shared package SHALL hold the op-code constants and an op enum typedef.
REQ-036 The LIFO SHALL be a sub-module pc_ras (parameters WIDTH, DEPTH; push, pop, push data, top data, sp, full, empty); pc_stack SHALL hold the PC register, next-PC mux and error flags.

Verification
REQ-037 Reset then INC x3 with RESET_VEC=0 -> out 0,1,2,3; INC from 16'hFFFF -> 16'h0000.
REQ-038 out=100, BRANCH in=16'hFFF6 -> out=90; BRANCH in=20 -> out=110; LOAD in=7 -> out=7, sp unchanged.
REQ-039 out=10, CALL in=200 -> out=200, sp=1; CALL in=300 -> out=300, sp=2; RET -> out=201, sp=1; RET -> out=11, sp=0, empty=1.
REQ-040 Fill DEPTH=8 calls -> full=1; 9th CALL in=55 -> out=55, sp=8, ovf=1; RET while empty after draining -> out held, unf=1; flags persist until clr.
REQ-041 stall=1 with op=CALL for 3 cycles -> out, sp, flags unchanged; clr and stall asserted together -> out=RESET_VEC, sp=0.
REQ-042 reset pulsed low between clock edges during a CALL sequence -> out=RESET_VEC and sp=0 before the next edge; the next op after release executes normally.
